// File: rtl/simmem_pkg.sv
// Shared types and sizing helpers for the simulated-memory release scheduler.
package simmem_pkg;

    localparam int DefaultIdWidth    = 2;
    localparam int DefaultDelayWidth = 8;
    localparam int DefaultNumSlots   = 8;

    // Slot sizing helper; a two-slot scheduler still needs one index/rank bit.
    function automatic int slot_idx_width(input int numSlots);
        return (numSlots <= 2) ? 1 : $clog2(numSlots);
    endfunction

    localparam int DefaultRankWidth = slot_idx_width(DefaultNumSlots);

    typedef struct packed {
        logic                         valid;
        logic [DefaultIdWidth-1:0]    id;
        logic [DefaultDelayWidth-1:0] counter;
        logic [DefaultRankWidth-1:0]  rank;
    } slot_t;

endpackage

// File: rtl/simmem_release_slot.sv
// One tracked entry: holds ID, countdown to maturity and its age rank among same-ID entries.
module simmem_release_slot #(
    parameter int IDWidth    = 2,
    parameter int DelayWidth = 8,
    parameter int RankWidth  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_load,
    input  logic [IDWidth-1:0]    i_loadId,
    input  logic [DelayWidth-1:0] i_loadDelay,
    input  logic [RankWidth-1:0]  i_loadRank,
    input  logic                  i_free,
    input  logic                  i_rankDec,
    output logic                  o_valid,
    output logic [IDWidth-1:0]    o_id,
    output logic [DelayWidth-1:0] o_counter,
    output logic [RankWidth-1:0]  o_rank
);

    logic                  r_valid;
    logic [IDWidth-1:0]    r_id;
    logic [DelayWidth-1:0] r_counter;
    logic [RankWidth-1:0]  r_rank;

    // Load only targets a free slot and free only a valid one, so they never collide.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_counter <= '0;
            r_rank    <= '0;
        end else if (i_load) begin
            r_valid   <= 1'b1;
            r_id      <= i_loadId;
            r_counter <= i_loadDelay;
            r_rank    <= i_loadRank;
        end else if (i_free) begin
            r_valid   <= 1'b0;
            r_counter <= '0;
            r_rank    <= '0;
        end else if (r_valid) begin
            if (r_counter != '0) begin
                r_counter <= r_counter - 1'b1;
            end
            if (i_rankDec && (r_rank != '0)) begin
                r_rank <= r_rank - 1'b1;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_id      = r_id;
    assign o_counter = r_counter;
    assign o_rank    = r_rank;

endmodule

// File: rtl/simmem_release_scheduler.sv
// Per-ID release timing engine for simmem_linkedlist_bank.
// Optional statistics outputs are enabled with `define SIMMEM_SCHED_STATS_EN.
module simmem_release_scheduler
    import simmem_pkg::*;
#(
    parameter int IDWidth    = DefaultIdWidth,
    parameter int NumSlots   = DefaultNumSlots,
    parameter int DelayWidth = DefaultDelayWidth
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [IDWidth-1:0]             in_id_i,
    input  logic [DelayWidth-1:0]          in_delay_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [IDWidth-1:0]             out_id_i,
    input  logic                           out_fire_i,
    output logic [2**IDWidth-1:0]          release_en_o,
    output logic [$clog2(NumSlots+1)-1:0]  pending_cnt_o,
`ifdef SIMMEM_SCHED_STATS_EN
    output logic [31:0]                    released_total_o,
    output logic [$clog2(NumSlots+1)-1:0]  max_pending_o,
`endif
    output logic                           err_o
);

    localparam int NumIds    = 2**IDWidth;
    localparam int RankWidth = slot_idx_width(NumSlots);
    localparam int CntWidth  = $clog2(NumSlots+1);

    logic [NumSlots-1:0]   w_slotValid;
    logic [IDWidth-1:0]    w_slotId      [NumSlots];
    logic [DelayWidth-1:0] w_slotCounter [NumSlots];
    logic [RankWidth-1:0]  w_slotRank    [NumSlots];

    logic [NumSlots-1:0]   w_load;
    logic [NumSlots-1:0]   w_free;
    logic [NumSlots-1:0]   w_rankDec;

    logic                  w_freeFound;
    logic [RankWidth-1:0]  w_freeIdx;
    logic [CntWidth-1:0]   w_sameIdCnt;
    logic [CntWidth-1:0]   w_insertRankFull;
    logic [RankWidth-1:0]  w_insertRank;
    logic                  w_insert;
    logic                  w_releaseFire;
    logic [CntWidth-1:0]   w_pendingNext;

    logic [CntWidth-1:0]   r_pendingCnt;
    logic                  r_err;

    // Lowest-index free slot wins; scanning downward leaves the smallest index last.
    always_comb begin
        w_freeFound = 1'b0;
        w_freeIdx   = '0;
        for (int k = NumSlots - 1; k >= 0; k--) begin
            if (!w_slotValid[k]) begin
                w_freeFound = 1'b1;
                w_freeIdx   = RankWidth'(k);
            end
        end
    end

    always_comb begin
        w_sameIdCnt = '0;
        for (int k = 0; k < NumSlots; k++) begin
            if (w_slotValid[k] && (w_slotId[k] == in_id_i)) begin
                w_sameIdCnt = w_sameIdCnt + CntWidth'(1);
            end
        end
    end

    always_comb begin
        release_en_o = '0;
        for (int k = 0; k < NumSlots; k++) begin
            if (w_slotValid[k] && (w_slotRank[k] == '0) && (w_slotCounter[k] == '0)) begin
                release_en_o[w_slotId[k]] = 1'b1;
            end
        end
    end

    assign in_ready_o    = w_freeFound;
    assign w_insert      = in_valid_i & w_freeFound;
    assign w_releaseFire = out_fire_i & release_en_o[out_id_i];

    // A same-ID release landing this cycle removes one older entry ahead of the newcomer.
    assign w_insertRankFull = w_sameIdCnt -
                              ((w_releaseFire && (out_id_i == in_id_i)) ? CntWidth'(1) : CntWidth'(0));
    assign w_insertRank     = RankWidth'(w_insertRankFull);

    for (genvar g = 0; g < NumSlots; g++) begin : gSlot
        logic w_match;

        assign w_match      = w_releaseFire & w_slotValid[g] & (w_slotId[g] == out_id_i);
        assign w_load[g]    = w_insert & (w_freeIdx == RankWidth'(g));
        assign w_free[g]    = w_match & (w_slotRank[g] == '0);
        assign w_rankDec[g] = w_match & (w_slotRank[g] != '0);

        simmem_release_slot #(
            .IDWidth    (IDWidth),
            .DelayWidth (DelayWidth),
            .RankWidth  (RankWidth)
        ) uSlot (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .i_load      (w_load[g]),
            .i_loadId    (in_id_i),
            .i_loadDelay (in_delay_i),
            .i_loadRank  (w_insertRank),
            .i_free      (w_free[g]),
            .i_rankDec   (w_rankDec[g]),
            .o_valid     (w_slotValid[g]),
            .o_id        (w_slotId[g]),
            .o_counter   (w_slotCounter[g]),
            .o_rank      (w_slotRank[g])
        );
    end

    always_comb begin
        w_pendingNext = r_pendingCnt;
        if (w_insert && !w_releaseFire) begin
            w_pendingNext = r_pendingCnt + CntWidth'(1);
        end else if (!w_insert && w_releaseFire) begin
            w_pendingNext = r_pendingCnt - CntWidth'(1);
        end
    end

    // The error flag is sticky so a single ordering violation is never lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pendingCnt <= '0;
            r_err        <= 1'b0;
        end else begin
            r_pendingCnt <= w_pendingNext;
            if (out_fire_i && !release_en_o[out_id_i]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pending_cnt_o = r_pendingCnt;
    assign err_o         = r_err;

`ifdef SIMMEM_SCHED_STATS_EN
    logic [31:0]         r_releasedTotal;
    logic [CntWidth-1:0] r_maxPending;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_releasedTotal <= '0;
            r_maxPending    <= '0;
        end else begin
            if (w_releaseFire) begin
                r_releasedTotal <= r_releasedTotal + 32'd1;
            end
            if (w_pendingNext > r_maxPending) begin
                r_maxPending <= w_pendingNext;
            end
        end
    end

    assign released_total_o = r_releasedTotal;
    assign max_pending_o    = r_maxPending;
`endif

    initial begin
        assert (NumSlots >= 2) else $fatal(1, "NumSlots must be at least 2");
    end

endmodule
